// File: rtl/pwm_pulse_mc.sv
// Multi-channel PWM burst/continuous pulse generator with per-channel busy/done status and enable-level abort.
// Optional macro PWM_PHASE_DELAY_EN adds a per-channel start delay (DELAY state); otherwise io_delay is ignored.
module pwm_pulse_mc #(
  parameter int CH         = 4,
  parameter int _RAM_WIDTH = 32
) (
  input  logic                       io_clk,
  input  logic                       io_rst_n,
  input  logic [CH-1:0]              io_en,
  input  logic [CH-1:0]              io_defaultLevel,
  input  logic [CH*_RAM_WIDTH-1:0]   io_pulseWidth,
  input  logic [CH*_RAM_WIDTH-1:0]   io_unaccessWidth,
  input  logic [CH*_RAM_WIDTH-1:0]   io_pulse_times,
  input  logic [CH*_RAM_WIDTH-1:0]   io_delay,
  output logic [CH-1:0]              io_pulseOut,
  output logic [CH-1:0]              pulse_valid,
  output logic [CH-1:0]              pulse_busy
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACTIVE, S_GAP} state_t;

`ifndef PWM_PHASE_DELAY_EN
  logic unused_delay;
  assign unused_delay = ^io_delay;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam logic [_RAM_WIDTH-1:0] ONE  = _RAM_WIDTH'(1);
    localparam logic [_RAM_WIDTH-1:0] ZERO = '0;

    state_t                  state_q, state_d;
    logic [_RAM_WIDTH-1:0]   cnt_q, cnt_d;
    logic [_RAM_WIDTH-1:0]   width_q, width_d;
    logic [_RAM_WIDTH-1:0]   gap_q, gap_d;
    logic [_RAM_WIDTH-1:0]   left_q, left_d;
    logic                    en_dly_q;
    logic                    out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic [_RAM_WIDTH-1:0]   fld_w, fld_u, fld_n, w_in, u_in;
    logic                    dflt, rise, fall;

    assign fld_w = io_pulseWidth[c*_RAM_WIDTH +: _RAM_WIDTH];
    assign fld_u = io_unaccessWidth[c*_RAM_WIDTH +: _RAM_WIDTH];
    assign fld_n = io_pulse_times[c*_RAM_WIDTH +: _RAM_WIDTH];
    // Zero widths become 1 so every pulse and gap is visible and no counter ever loads 0.
    assign w_in  = (fld_w == ZERO) ? ONE : fld_w;
    assign u_in  = (fld_u == ZERO) ? ONE : fld_u;
    assign dflt  = io_defaultLevel[c];
    assign rise  = io_en[c] & ~en_dly_q;
    assign fall  = ~io_en[c] & en_dly_q;
`ifdef PWM_PHASE_DELAY_EN
    logic [_RAM_WIDTH-1:0] fld_dl;
    assign fld_dl = io_delay[c*_RAM_WIDTH +: _RAM_WIDTH];
`endif

    always_ff @(posedge io_clk or negedge io_rst_n) begin
      if (!io_rst_n) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        width_q  <= '0;
        gap_q    <= '0;
        left_q   <= '0;
        en_dly_q <= 1'b0;
        out_q    <= 1'b0;
        valid_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        width_q  <= width_d;
        gap_q    <= gap_d;
        left_q   <= left_d;
        en_dly_q <= io_en[c];
        out_q    <= out_d;
        valid_q  <= valid_d;
        busy_q   <= busy_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      width_d = width_q;
      gap_d   = gap_q;
      left_d  = left_q;
      out_d   = out_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
        S_IDLE: begin
          out_d  = dflt;
          busy_d = 1'b0;
          if (rise) begin
            width_d = w_in;
            gap_d   = u_in;
            left_d  = fld_n;
            busy_d  = 1'b1;
`ifdef PWM_PHASE_DELAY_EN
            if (fld_dl != ZERO) begin
              state_d = S_DELAY;
              cnt_d   = fld_dl;
            end else begin
              state_d = S_ACTIVE;
              cnt_d   = w_in;
              out_d   = ~dflt;
            end
`else
            state_d = S_ACTIVE;
            cnt_d   = w_in;
            out_d   = ~dflt;
`endif
          end
        end
`ifdef PWM_PHASE_DELAY_EN
        S_DELAY: begin
          out_d = dflt;
          if (cnt_q == ONE) begin
            state_d = S_ACTIVE;
            cnt_d   = width_q;
            out_d   = ~dflt;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
`endif
        S_ACTIVE: begin
          out_d = ~dflt;
          if (cnt_q == ONE) begin
            state_d = S_GAP;
            cnt_d   = gap_q;
            out_d   = dflt;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        S_GAP: begin
          out_d = dflt;
          if (cnt_q != ONE) begin
            cnt_d = cnt_q - ONE;
          end else if (left_q == ZERO) begin
            // Continuous mode picks up new width/gap only at a pulse boundary.
            state_d = S_ACTIVE;
            width_d = w_in;
            gap_d   = u_in;
            cnt_d   = w_in;
            out_d   = ~dflt;
          end else if (left_q == ONE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            cnt_d   = ZERO;
            left_d  = ZERO;
          end else begin
            state_d = S_ACTIVE;
            left_d  = left_q - ONE;
            cnt_d   = width_q;
            out_d   = ~dflt;
          end
        end
        default: begin
          state_d = S_IDLE;
          out_d   = dflt;
          busy_d  = 1'b0;
        end
      endcase
      // Abort overrides a same-cycle done, so only one strobe can result.
      if (fall && (state_q != S_IDLE)) begin
        state_d = S_IDLE;
        out_d   = dflt;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        cnt_d   = ZERO;
        left_d  = ZERO;
        width_d = ZERO;
        gap_d   = ZERO;
      end
    end

    assign io_pulseOut[c] = out_q;
    assign pulse_valid[c] = valid_q;
    assign pulse_busy[c]  = busy_q;
  end

endmodule
